// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S sample receiver.
package i2s_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Emit mask indexed by slot: bit CH_LEFT for WS-low words, bit CH_RIGHT for WS-high words.
  function automatic logic [1:0] emit_mask(input string ch);
    logic [1:0] m;
    m = 2'b00;
    if (ch == "left")       m = 2'b01;
    else if (ch == "right") m = 2'b10;
    else if (ch == "both")  m = 2'b11;
    return m;
  endfunction

endpackage

// File: rtl/i2s_sample_rx_sync_edge_det.sv
// Multi-bit 2-FF synchroniser with an extra stage for edge detection.
module sync_edge_det #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] lvl_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] s1_q, s2_q, s3_q;

  // Two metastability stages followed by the previous-level register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/i2s_sample_rx.sv
// I2S receiver: oversampled pins, MSB-first deserialiser, one strobe per emitted slot.
module i2s_sample_rx
  import i2s_pkg::*;
#(
  parameter int    DW      = 16,
  parameter string CHANNEL = "left",
  parameter int    TIMEOUT = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i2s_sck_i,
  input  logic          i2s_ws_i,
  input  logic          i2s_sd_i,
  output logic [DW-1:0] data_o,
  output logic          start_o,
  output logic          chan_o,
  output logic          lost_o
);

  localparam int         CW   = $clog2(DW + 1);
  localparam int         IW   = $clog2(TIMEOUT + 1);
  localparam logic [1:0] EMIT = emit_mask(CHANNEL);

  // Pin bit order: 0 = SCK, 1 = WS, 2 = SD. WS/SD share SCK's synchroniser depth.
  logic [2:0] pin_lvl, pin_rise, pin_fall;

  sync_edge_det #(.W(3)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({i2s_sd_i, i2s_ws_i, i2s_sck_i}),
    .lvl_o  (pin_lvl),
    .rise_o (pin_rise),
    .fall_o (pin_fall)
  );

  logic rise, ws, sd;
  assign rise = pin_rise[0];
  assign ws   = pin_lvl[1];
  assign sd   = pin_lvl[2];

  logic unused_pins;
  assign unused_pins = ^{pin_lvl[0], pin_rise[2:1], pin_fall};

  state_e          state_q, state_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ws_prev_q, ws_prev_d;
  logic            ws_vld_q, ws_vld_d;   // ws_prev_q holds a real sample
  logic [IW-1:0]   idle_q, idle_d;
  logic [DW-1:0]   data_q, data_d;
  logic            start_q, start_d;
  logic            chan_q, chan_d;
  logic            lost_q, lost_d;

  logic [DW-1:0]   sr_sh;
  logic [CW-1:0]   cnt_sh;
  logic            ws_chg;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SYNC;
      sr_q      <= '0;
      cnt_q     <= '0;
      ws_prev_q <= 1'b0;
      ws_vld_q  <= 1'b0;
      idle_q    <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      chan_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ws_prev_q <= ws_prev_d;
      ws_vld_q  <= ws_vld_d;
      idle_q    <= idle_d;
      data_q    <= data_d;
      start_q   <= start_d;
      chan_q    <= chan_d;
      lost_q    <= lost_d;
    end
  end

  // Next state: shift on SCK rise, emit on WS change, drop to SYNC on idle timeout.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ws_prev_d = ws_prev_q;
    ws_vld_d  = ws_vld_q;
    idle_d    = idle_q;
    data_d    = data_q;
    chan_d    = chan_q;
    start_d   = 1'b0;
    lost_d    = 1'b0;

    // Candidate shift: bit k lands at sr[DW-1-k]; bits beyond DW are dropped.
    sr_sh  = sr_q;
    cnt_sh = cnt_q;
    if (cnt_q < CW'(DW)) begin
      for (int i = 0; i < DW; i++)
        if (cnt_q == CW'(DW - 1 - i)) sr_sh[i] = sd;
      cnt_sh = cnt_q + CW'(1);
    end

    ws_chg = ws_vld_q && (ws != ws_prev_q);

    if (rise) begin
      idle_d    = '0;
      ws_prev_d = ws;
      ws_vld_d  = 1'b1;
      unique case (state_q)
        SYNC: begin
          if (ws_chg) begin
            state_d = RECV;
            sr_d    = '0;
            cnt_d   = '0;
          end
        end
        RECV: begin
          if (!ws_chg) begin
            sr_d  = sr_sh;
            cnt_d = cnt_sh;
          end else begin
            // The bit on the WS-change rise is the LSB slot of the ending word.
            if (cnt_sh != '0 && EMIT[ws_prev_q]) begin
              data_d  = sr_sh;
              chan_d  = ws_prev_q;
              start_d = 1'b1;
            end
            sr_d  = '0;
            cnt_d = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end else if (idle_q != IW'(TIMEOUT)) begin
      idle_d = idle_q + IW'(1);
      if (idle_d == IW'(TIMEOUT)) begin
        lost_d   = 1'b1;
        state_d  = SYNC;
        sr_d     = '0;
        cnt_d    = '0;
        ws_vld_d = 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign start_o = start_q;
  assign chan_o  = chan_q;
  assign lost_o  = lost_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Directed bench: a "left" and a "both" receiver share the same I2S pins.
module tb_i2s_sample_rx;

  localparam int DW = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0, ws = 1'b0, sd = 1'b0;

  always #5 clk = ~clk;

  logic [DW-1:0] l_data, b_data;
  logic          l_start, l_chan, l_lost;
  logic          b_start, b_chan, b_lost;

  i2s_sample_rx #(.DW(DW), .CHANNEL("left"), .TIMEOUT(TO)) u_left (
    .clk_i(clk), .rst_ni(rst_n), .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_i(sd),
    .data_o(l_data), .start_o(l_start), .chan_o(l_chan), .lost_o(l_lost)
  );

  i2s_sample_rx #(.DW(DW), .CHANNEL("both"), .TIMEOUT(TO)) u_both (
    .clk_i(clk), .rst_ni(rst_n), .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_i(sd),
    .data_o(b_data), .start_o(b_start), .chan_o(b_chan), .lost_o(b_lost)
  );

  // Strobe recorder
  logic [DW-1:0] lq_d[$], bq_d[$];
  logic          lq_c[$], bq_c[$];
  int            l_lost_n = 0, b_lost_n = 0;

  always @(negedge clk) begin
    if (l_start) begin lq_d.push_back(l_data); lq_c.push_back(l_chan); end
    if (b_start) begin bq_d.push_back(b_data); bq_c.push_back(b_chan); end
    if (l_lost) l_lost_n++;
    if (b_lost) b_lost_n++;
  end

  int tests = 0, failed = 0;

  task automatic send_bit(input logic w, input logic d);
    ws = w; sd = d;
    repeat (4) @(posedge clk);
    sck = 1'b1;
    repeat (4) @(posedge clk);
    sck = 1'b0;
  endtask

  // n bits MSB first; the LSB goes out with the next slot's WS level
  task automatic send_word(input logic c, input logic nxt, input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) send_bit((k == n - 1) ? nxt : c, v[n-1-k]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (l_data !== 16'h0) begin failed++; $display("FAIL reset_l_data: got %h want 0000", l_data); end
    tests++; if (b_data !== 16'h0) begin failed++; $display("FAIL reset_b_data: got %h want 0000", b_data); end
    tests++; if ({l_start, b_start} !== 2'b00) begin failed++; $display("FAIL reset_start: got %b want 00", {l_start, b_start}); end
    tests++; if ({l_chan, b_chan} !== 2'b00) begin failed++; $display("FAIL reset_chan: got %b want 00", {l_chan, b_chan}); end
    tests++; if ({l_lost, b_lost} !== 2'b00) begin failed++; $display("FAIL reset_lost: got %b want 00", {l_lost, b_lost}); end
  endtask

  task automatic test_nominal();
    int lb, bb;
    logic [15:0] ed[5];
    logic        ec[5];
    ed = '{16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001, 16'h7FFF};
    ec = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    lb = lq_d.size(); bb = bq_d.size();
    repeat (3) begin
      send_word(1'b0, 1'b1, 32'h8001, 16);
      send_word(1'b1, 1'b0, 32'h7FFF, 16);
    end
    settle();
    tests++; if (lq_d.size() - lb !== 2) begin failed++; $display("FAIL nominal_left_count: got %0d want 2", lq_d.size() - lb); end
    for (int i = 0; i < 2; i++) if (lb + i < lq_d.size()) begin
      tests++; if (lq_d[lb+i] !== 16'h8001 || lq_c[lb+i] !== 1'b0) begin failed++;
        $display("FAIL nominal_left[%0d]: got %h/%b want 8001/0", i, lq_d[lb+i], lq_c[lb+i]); end
    end
    tests++; if (bq_d.size() - bb !== 5) begin failed++; $display("FAIL nominal_both_count: got %0d want 5", bq_d.size() - bb); end
    for (int i = 0; i < 5; i++) if (bb + i < bq_d.size()) begin
      tests++; if (bq_d[bb+i] !== ed[i] || bq_c[bb+i] !== ec[i]) begin failed++;
        $display("FAIL nominal_both[%0d]: got %h/%b want %h/%b", i, bq_d[bb+i], bq_c[bb+i], ed[i], ec[i]); end
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    tests++; if (l_data !== 16'h8001 || l_chan !== 1'b0) begin failed++; $display("FAIL nominal_hold: got %h/%b want 8001/0", l_data, l_chan); end
  endtask

  task automatic test_truncation();
    int bb;
    logic [15:0] ed[3];
    logic        ec[3];
    ed = '{16'hABCD, 16'h1234, 16'hABCD};
    ec = '{1'b1, 1'b0, 1'b1};
    do_reset();
    bb = bq_d.size();
    repeat (2) begin
      send_word(1'b0, 1'b1, 32'h123456, 24);
      send_word(1'b1, 1'b0, 32'hABCDEF, 24);
    end
    settle();
    tests++; if (bq_d.size() - bb !== 3) begin failed++; $display("FAIL trunc_count: got %0d want 3", bq_d.size() - bb); end
    for (int i = 0; i < 3; i++) if (bb + i < bq_d.size()) begin
      tests++; if (bq_d[bb+i] !== ed[i] || bq_c[bb+i] !== ec[i]) begin failed++;
        $display("FAIL trunc[%0d]: got %h/%b want %h/%b", i, bq_d[bb+i], bq_c[bb+i], ed[i], ec[i]); end
    end
  endtask

  task automatic test_padding();
    int lb, bb;
    logic [15:0] ed[3];
    ed = '{16'hC300, 16'h5A00, 16'hC300};
    do_reset();
    lb = lq_d.size(); bb = bq_d.size();
    repeat (2) begin
      send_word(1'b0, 1'b1, 32'h5A, 8);
      send_word(1'b1, 1'b0, 32'hC3, 8);
    end
    settle();
    tests++; if (lq_d.size() - lb !== 1) begin failed++; $display("FAIL pad_left_count: got %0d want 1", lq_d.size() - lb); end
    else begin
      tests++; if (lq_d[lb] !== 16'h5A00) begin failed++; $display("FAIL pad_left: got %h want 5A00", lq_d[lb]); end
    end
    tests++; if (bq_d.size() - bb !== 3) begin failed++; $display("FAIL pad_both_count: got %0d want 3", bq_d.size() - bb); end
    for (int i = 0; i < 3; i++) if (bb + i < bq_d.size()) begin
      tests++; if (bq_d[bb+i] !== ed[i]) begin failed++; $display("FAIL pad_both[%0d]: got %h want %h", i, bq_d[bb+i], ed[i]); end
    end
  endtask

  task automatic test_startup();
    int lb, bb;
    do_reset();
    lb = lq_d.size(); bb = bq_d.size();
    repeat (4) send_bit(1'b1, 1'b1);   // tail of a right word already in flight
    send_bit(1'b0, 1'b1);              // its LSB, first WS transition seen
    settle();
    tests++; if (bq_d.size() - bb !== 0) begin failed++; $display("FAIL startup_early: got %0d strobes want 0", bq_d.size() - bb); end
    send_word(1'b0, 1'b1, 32'h1111, 16);
    send_word(1'b1, 1'b0, 32'h2222, 16);
    settle();
    tests++; if (bq_d.size() - bb !== 2) begin failed++; $display("FAIL startup_count: got %0d want 2", bq_d.size() - bb); end
    else begin
      tests++; if (bq_d[bb] !== 16'h1111 || bq_c[bb] !== 1'b0) begin failed++; $display("FAIL startup_first: got %h/%b want 1111/0", bq_d[bb], bq_c[bb]); end
      tests++; if (bq_d[bb+1] !== 16'h2222 || bq_c[bb+1] !== 1'b1) begin failed++; $display("FAIL startup_second: got %h/%b want 2222/1", bq_d[bb+1], bq_c[bb+1]); end
    end
    tests++; if (lq_d.size() - lb !== 1) begin failed++; $display("FAIL startup_left_count: got %0d want 1", lq_d.size() - lb); end
  endtask

  task automatic test_timeout();
    int lb, bb, ll, bl;
    do_reset();
    send_word(1'b0, 1'b1, 32'h0A0A, 16);
    send_word(1'b1, 1'b0, 32'h0B0B, 16);
    repeat (7) send_bit(1'b0, 1'b1);   // partial left word
    settle();
    lb = lq_d.size(); bb = bq_d.size(); ll = l_lost_n; bl = b_lost_n;
    repeat (TO + 10) @(posedge clk);
    @(negedge clk);
    tests++; if (l_lost_n - ll !== 1 || b_lost_n - bl !== 1) begin failed++;
      $display("FAIL timeout_lost: got %0d/%0d want 1/1", l_lost_n - ll, b_lost_n - bl); end
    tests++; if (bq_d.size() - bb !== 0 || lq_d.size() - lb !== 0) begin failed++;
      $display("FAIL timeout_no_start: got %0d/%0d want 0/0", lq_d.size() - lb, bq_d.size() - bb); end
    send_word(1'b0, 1'b1, 32'h01FF, 9); // rest of the interrupted word
    send_word(1'b1, 1'b0, 32'h2468, 16);
    send_word(1'b0, 1'b1, 32'h1357, 16);
    settle();
    tests++; if (bq_d.size() - bb !== 2) begin failed++; $display("FAIL timeout_resume_count: got %0d want 2", bq_d.size() - bb); end
    else begin
      tests++; if (bq_d[bb] !== 16'h2468 || bq_c[bb] !== 1'b1) begin failed++; $display("FAIL timeout_resume0: got %h/%b want 2468/1", bq_d[bb], bq_c[bb]); end
      tests++; if (bq_d[bb+1] !== 16'h1357 || bq_c[bb+1] !== 1'b0) begin failed++; $display("FAIL timeout_resume1: got %h/%b want 1357/0", bq_d[bb+1], bq_c[bb+1]); end
    end
    tests++; if (l_lost_n - ll !== 1) begin failed++; $display("FAIL timeout_single: got %0d want 1", l_lost_n - ll); end
  endtask

  task automatic test_reset_mid();
    int lb, bb;
    do_reset();
    repeat (2) begin
      send_word(1'b0, 1'b1, 32'h4321, 16);
      send_word(1'b1, 1'b0, 32'h8765, 16);
    end
    repeat (7) send_bit(1'b0, 1'b1);
    @(negedge clk);
    tests++; if (l_data !== 16'h4321 || b_chan !== 1'b1) begin failed++; $display("FAIL midrst_pre: got %h/%b want 4321/1", l_data, b_chan); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++; if (l_data !== 16'h0 || b_data !== 16'h0) begin failed++; $display("FAIL midrst_data: got %h/%h want 0000/0000", l_data, b_data); end
    tests++; if ({l_start, b_start, l_chan, b_chan, l_lost, b_lost} !== 6'b0) begin failed++;
      $display("FAIL midrst_ctrl: got %b want 000000", {l_start, b_start, l_chan, b_chan, l_lost, b_lost}); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    lb = lq_d.size(); bb = bq_d.size();
    send_word(1'b0, 1'b1, 32'h01FF, 9);
    settle();
    tests++; if (bq_d.size() - bb !== 0 || lq_d.size() - lb !== 0) begin failed++;
      $display("FAIL midrst_stale: got %0d/%0d want 0/0", lq_d.size() - lb, bq_d.size() - bb); end
    send_word(1'b1, 1'b0, 32'h0246, 16);
    send_word(1'b0, 1'b1, 32'h0135, 16);
    settle();
    tests++; if (bq_d.size() - bb !== 2) begin failed++; $display("FAIL midrst_count: got %0d want 2", bq_d.size() - bb); end
    else begin
      tests++; if (bq_d[bb] !== 16'h0246 || bq_c[bb] !== 1'b1) begin failed++; $display("FAIL midrst_first: got %h/%b want 0246/1", bq_d[bb], bq_c[bb]); end
    end
    tests++; if (lq_d.size() - lb !== 1) begin failed++; $display("FAIL midrst_left_count: got %0d want 1", lq_d.size() - lb); end
    else begin
      tests++; if (lq_d[lb] !== 16'h0135) begin failed++; $display("FAIL midrst_left: got %h want 0135", lq_d[lb]); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_truncation();
    test_padding();
    test_startup();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/i2s_sample_rx.md
# i2s_sample_rx

Serial audio (I2S) receiver that feeds the cascaded SOS IIR filter. Oversamples the external SCK/WS/SD pins in the `clk_i` domain, deserialises MSB-first words and presents one parallel `DW`-bit sample per frame slot. Each sample comes with a single-cycle strobe that drives the filter's `start_i`, and `data_o` connects directly to the filter's `data_i`.

## Interface

Parameters:

- `DW`, 16: output sample width; must match the filter `DW`.
- `CHANNEL`, "left": which slots are emitted: "left" (WS low), "right" (WS high) or "both".
- `TIMEOUT`, 1024: `clk_i` cycles without an SCK rising edge before the link is declared lost.

Ports:

- `clk_i`, in, 1: system clock; must run at least 4× the SCK frequency.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `i2s_sck_i`, in, 1: serial bit clock, asynchronous to `clk_i`.
- `i2s_ws_i`, in, 1: word select, asynchronous.
- `i2s_sd_i`, in, 1: serial data, asynchronous.
- `data_o`, out, `DW`: signed sample, two's complement, held between strobes.
- `start_o`, out, 1: one-cycle pulse, new `data_o` valid.
- `chan_o`, out, 1: slot of the current `data_o`; 0 is left, 1 is right.
- `lost_o`, out, 1: one-cycle pulse on link-loss timeout.

## Operation

- **Pin synchronisation:** each pin passes through a 2-FF synchroniser. The synchronised SCK is then registered once more to detect edges. All logic acts only on cycles where an SCK rise is detected (`rise`).
- **States:**
  - SYNC is the reset state. Incoming bits are ignored. On the first `rise` where synchronised WS differs from its previously sampled value, clear the shift register and bit counter and go to RECV.
  - RECV: on each `rise`, if WS has not changed, shift the SD bit in.
    - Bit k of a word (k counted from 0) is written to `sr[DW-1-k]` while k < `DW`.
    - Bits with k ≥ `DW` are dropped, so long words are truncated to their MSBs.
    - Short words leave the remaining LSBs at 0, so they are left-justified.
    - The bit counter saturates at `DW`.
  - Word end: on a `rise` where WS differs from the previous WS sample:
    - The SD bit sampled on that `rise` is the LSB slot of the ending word and is shifted in under the same rules.
    - The completed word is emitted if its slot (the previous WS value) matches `CHANNEL`.
    - The shift register and counter are then cleared and the new slot begins.
- **Zero-length words:** a word that ends with 0 bits received is never emitted.
- **Timeout:** an idle counter resets on every `rise`. When it reaches `TIMEOUT` in any state:
  - pulse `lost_o`,
  - go to SYNC,
  - discard the partial word.
  - In SYNC the counter saturates, so `lost_o` pulses only once per loss.
- **Reset:** asserting `rst_ni` at any time, including mid-word, immediately clears every register. Outputs reset to `data_o`=0, `start_o`=0, `chan_o`=0, `lost_o`=0, and the state returns to SYNC.
- **Simultaneous word end and timeout:** cannot occur, because a `rise` clears the idle counter. If the counter reaches `TIMEOUT` on the same cycle as a `rise`, the `rise` wins.

## Timing

- `rise` is detected 2 `clk_i` edges after the SCK rising edge is first captured by the synchroniser.
- `start_o`, `data_o` and `chan_o` update on the next edge: 3 `clk_i` edges from first capture to the strobe.
- `start_o` is high for exactly 1 cycle. `data_o` and `chan_o` are stable until the next strobe.
- Minimum strobe spacing is one SCK slot. The downstream filter must complete its calculation within one slot, and this block does not apply backpressure.
- SCK high and low phases must each last at least 2 `clk_i` periods.
- SD and WS are launched on SCK falling edges and are sampled at the SCK rise through the same 2-FF synchroniser depth, so their phase relative to SCK is preserved.

## Structure

- **Shared package** `i2s_pkg`:
  - state enum {SYNC, RECV},
  - channel encoding constants `CH_LEFT`=0 and `CH_RIGHT`=1,
  - a function mapping the `CHANNEL` string to an emit mask.
- **Sub-module** `sync_edge_det`: 2-FF synchroniser plus edge register, parameterised width, output ports for synchronised level and rise/fall pulses. Instantiate it once, 3 bits wide, for SCK, WS and SD.
- **Top** holds the FSM, shift register, bit counter, idle counter and output registers.

## Test plan

1. **Nominal 16-bit stereo:** `DW`=16, `CHANNEL`="left", 16-bit slots, left word 0x8001, right word 0x7FFF. Expect after the first sync slot:
   - `start_o` once per frame,
   - `data_o`=0x8001, `chan_o`=0,
   - right word never emitted.
2. **Truncation:** `CHANNEL`="both", 24-bit slots carrying 0x123456 and 0xABCDEF. Expect `data_o`=0x1234 then 0xABCD, with `chan_o` alternating 0,1.
3. **Padding:** 8-bit slots carrying 0x5A. Expect `data_o`=0x5A00.
4. **Startup sync:** WS starts mid-word after reset. Expect no strobe until the first WS transition, and the first emitted word is the first complete slot.
5. **Timeout:** stop SCK for `TIMEOUT`+10 cycles. Expect:
   - exactly one `lost_o` pulse,
   - no `start_o`,
   - after SCK restarts, the next partial slot is discarded and normal output resumes.
6. **Reset mid-word:** assert `rst_ni` after 7 bits of a slot. Expect all outputs 0 immediately and no stale strobe after release.
